// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: flag hunt, zero-bit destuffing, LSB-first byte assembly,
// and frame close, error and abort signalling.
module hdlc_rx_deframer (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rxen,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame,
    output logic       validframe,
    output logic       abortframe,
    output logic       frameerr,
    output logic [7:0] counter
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam logic [BYTE_W-1:0] FLAG_PAT  = 8'h7E;
    localparam logic [BYTE_W-1:0] CNT_SAT   = 8'hFF;
    localparam logic [CNT_W-1:0]  ONES_MAX  = 3'd7;
    localparam logic [CNT_W-1:0]  ONES_STUF = 3'd5;
    localparam logic [CNT_W-1:0]  ONES_ABRT = 3'd6;
    localparam logic [CNT_W-1:0]  BIT_FLAG  = 3'd6;
    localparam logic [CNT_W-1:0]  BIT_LAST  = 3'd7;

    typedef enum logic {HUNT, FRAME} state_e;

    state_e              state_q, state_d;
    logic [BYTE_W-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]    ones_q, ones_d;
    logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
    logic [BYTE_W-1:0]   asm_q, asm_d;
    logic [BYTE_W-1:0]   hold_q, hold_d;
    logic                hold_full_q, hold_full_d;
    logic                cnt_clr_q, cnt_clr_d;
    logic [BYTE_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                validframe_q, validframe_d;
    logic                abortframe_q, abortframe_d;
    logic                frameerr_q, frameerr_d;
    logic [BYTE_W-1:0]   counter_q, counter_d;

    logic [BYTE_W-1:0]   sr_new;
    logic [BYTE_W-1:0]   asm_new;
    logic [CNT_W-1:0]    ones_new;
    logic [BYTE_W-1:0]   cnt_inc;
    logic                flag_det;
    logic                abort_det;
    logic                assemble;

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        ones_d       = ones_q;
        bitcnt_d     = bitcnt_q;
        asm_d        = asm_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        cnt_clr_d    = cnt_clr_q;
        rx_data_d    = rx_data_q;
        counter_d    = counter_q;
        rx_valid_d   = 1'b0;
        validframe_d = 1'b0;
        abortframe_d = 1'b0;
        frameerr_d   = 1'b0;

        sr_new    = {rx, sr_q[BYTE_W-1:1]};
        asm_new   = {rx, asm_q[BYTE_W-1:1]};
        ones_new  = rx ? ((ones_q == ONES_MAX) ? ONES_MAX : ones_q + 3'd1) : 3'd0;
        flag_det  = (sr_new == FLAG_PAT);
        abort_det = rx && (ones_q == ONES_ABRT);
        // Stuffed zeros (after exactly five ones) and ones beyond the fifth never reach the byte.
        assemble  = rx ? (ones_q < ONES_STUF) : (ones_q != ONES_STUF);
        // First emit after a closed frame restarts the byte count.
        cnt_inc   = cnt_clr_q ? 8'd1 : ((counter_q == CNT_SAT) ? CNT_SAT : counter_q + 8'd1);

        if (rxen) begin
            sr_d   = sr_new;
            ones_d = ones_new;
            case (state_q)
                HUNT: begin
                    if (flag_det) begin
                        state_d     = FRAME;
                        bitcnt_d    = 3'd0;
                        hold_full_d = 1'b0;
                        counter_d   = 8'd0;
                        cnt_clr_d   = 1'b0;
                    end
                end
                FRAME: begin
                    if (flag_det) begin
                        bitcnt_d    = 3'd0;
                        hold_full_d = 1'b0;
                        if (bitcnt_q == BIT_FLAG && hold_full_q) begin
                            // Closing flag doubles as the opening flag of the next frame.
                            rx_data_d    = hold_q;
                            rx_valid_d   = 1'b1;
                            validframe_d = 1'b1;
                            counter_d    = cnt_inc;
                            cnt_clr_d    = 1'b1;
                        end else begin
                            frameerr_d = (bitcnt_q != BIT_FLAG);
                            counter_d  = 8'd0;
                            cnt_clr_d  = 1'b0;
                        end
                    end else if (abort_det) begin
                        state_d      = HUNT;
                        abortframe_d = 1'b1;
                        bitcnt_d     = 3'd0;
                        hold_full_d  = 1'b0;
                        counter_d    = 8'd0;
                        cnt_clr_d    = 1'b0;
                    end else if (assemble) begin
                        asm_d    = asm_new;
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == BIT_LAST) begin
                            hold_d      = asm_new;
                            hold_full_d = 1'b1;
                            if (hold_full_q) begin
                                rx_data_d  = hold_q;
                                rx_valid_d = 1'b1;
                                counter_d  = cnt_inc;
                                cnt_clr_d  = 1'b0;
                            end
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= HUNT;
            sr_q         <= '0;
            ones_q       <= '0;
            bitcnt_q     <= '0;
            asm_q        <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            cnt_clr_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            validframe_q <= 1'b0;
            abortframe_q <= 1'b0;
            frameerr_q   <= 1'b0;
            counter_q    <= '0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            ones_q       <= ones_d;
            bitcnt_q     <= bitcnt_d;
            asm_q        <= asm_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            cnt_clr_q    <= cnt_clr_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            validframe_q <= validframe_d;
            abortframe_q <= abortframe_d;
            frameerr_q   <= frameerr_d;
            counter_q    <= counter_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame      = (state_q == FRAME);
    assign validframe = validframe_q;
    assign abortframe = abortframe_q;
    assign frameerr   = frameerr_q;
    assign counter    = counter_q;

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Directed bench for hdlc_rx_deframer: stuffed serial frames in, emitted bytes and
// frame pulses logged on the falling edge and compared to hand-computed values.
module tb_hdlc_rx_deframer;
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       rxen  = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame;
    logic       validframe;
    logic       abortframe;
    logic       frameerr;
    logic [7:0] counter;

    always #5 clk_i = ~clk_i;

    hdlc_rx_deframer dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rxen       (rxen),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame      (frame),
        .validframe (validframe),
        .abortframe (abortframe),
        .frameerr   (frameerr),
        .counter    (counter)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int rv_cnt = 0, vf_cnt = 0, ab_cnt = 0, fe_cnt = 0, vf_rv_cnt = 0;
    logic [7:0] rv_log [0:63];

    // Each one-cycle pulse is seen at exactly one falling edge.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (rx_valid) begin
                rv_log[6'(rv_cnt)] = rx_data;
                rv_cnt++;
            end
            if (validframe) begin
                vf_cnt++;
                if (rx_valid) vf_rv_cnt++;
            end
            if (abortframe) ab_cnt++;
            if (frameerr)   fe_cnt++;
        end
    end

    int rv0, vf0, ab0, fe0, vfrv0;
    int tx_ones;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        rv0 = rv_cnt; vf0 = vf_cnt; ab0 = ab_cnt; fe0 = fe_cnt; vfrv0 = vf_rv_cnt;
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        rxen  = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        tx_ones = 0;
        @(negedge clk_i);
        #1;
        snap();
    endtask

    task automatic send_bit(input logic b, input int gap);
        rx   = b;
        rxen = 1'b1;
        @(negedge clk_i);
        rxen = 1'b0;
        repeat (gap) @(negedge clk_i);
    endtask

    task automatic send_raw(input logic [7:0] d, input int n, input int gap);
        logic [7:0] v;
        v = d;
        for (int i = 0; i < n; i++) send_bit(v[i], gap);
        tx_ones = 0;
    endtask

    task automatic send_flag(input int gap);
        send_raw(8'h7E, 8, gap);
    endtask

    task automatic send_byte(input logic [7:0] d, input int gap);
        logic [7:0] v;
        v = d;
        for (int i = 0; i < 8; i++) begin
            send_bit(v[i], gap);
            tx_ones = v[i] ? tx_ones + 1 : 0;
            if (tx_ones == 5) begin
                send_bit(1'b0, gap);
                tx_ones = 0;
            end
        end
    endtask

    task automatic settle();
        rxen = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
    endtask

    initial begin
        tx_ones = 0;
        #2;
        #1;
        check("reset_rx_data",    32'(rx_data),    32'h00);
        check("reset_rx_valid",   32'(rx_valid),   32'h0);
        check("reset_frame",      32'(frame),      32'h0);
        check("reset_validframe", 32'(validframe), 32'h0);
        check("reset_abortframe", 32'(abortframe), 32'h0);
        check("reset_frameerr",   32'(frameerr),   32'h0);
        check("reset_counter",    32'(counter),    32'h00);

        // Idle ones in HUNT, then two bytes with a closing flag
        apply_reset();
        send_raw(8'hFF, 8, 0);
        send_raw(8'hFF, 4, 0);
        settle();
        check("idle_no_abort", 32'(ab_cnt - ab0), 32'd0);
        check("idle_frame",    32'(frame),        32'h0);
        send_flag(0);
        send_byte(8'hA5, 0);
        send_byte(8'h3C, 0);
        send_flag(0);
        settle();
        check("two_rv_count",  32'(rv_cnt - rv0),      32'd2);
        check("two_byte0",     32'(rv_log[6'(rv0)]),   32'hA5);
        check("two_byte1",     32'(rv_log[6'(rv0+1)]), 32'h3C);
        check("two_vf_count",  32'(vf_cnt - vf0),      32'd1);
        check("two_vf_with_rv",32'(vf_rv_cnt - vfrv0), 32'd1);
        check("two_counter",   32'(counter),           32'd2);
        check("two_no_fe",     32'(fe_cnt - fe0),      32'd0);
        check("two_frame_kept",32'(frame),             32'h1);

        // 0xFF after a shared flag: stuffed zero removed
        snap();
        send_byte(8'hFF, 0);
        send_flag(0);
        settle();
        check("ff_rv_count", 32'(rv_cnt - rv0),    32'd1);
        check("ff_data",     32'(rv_log[6'(rv0)]), 32'hFF);
        check("ff_vf",       32'(vf_cnt - vf0),    32'd1);
        check("ff_counter",  32'(counter),         32'd1);

        // Abort inside a frame
        apply_reset();
        send_flag(0);
        send_byte(8'h55, 0);
        send_raw(8'h7F, 7, 0);
        settle();
        check("abort_pulse", 32'(ab_cnt - ab0), 32'd1);
        check("abort_no_vf", 32'(vf_cnt - vf0), 32'd0);
        check("abort_no_rv", 32'(rv_cnt - rv0), 32'd0);
        check("abort_frame", 32'(frame),        32'h0);

        // Closing flag three bits off byte alignment
        apply_reset();
        send_flag(0);
        send_byte(8'h55, 0);
        send_raw(8'h00, 3, 0);
        send_flag(0);
        settle();
        check("ferr_pulse", 32'(fe_cnt - fe0), 32'd1);
        check("ferr_no_vf", 32'(vf_cnt - vf0), 32'd0);
        check("ferr_frame", 32'(frame),        32'h1);

        // Back-to-back flags, sparse rxen
        apply_reset();
        send_raw(8'hFF, 8, 3);
        send_flag(3);
        send_flag(3);
        send_flag(3);
        send_byte(8'h81, 3);
        send_flag(3);
        settle();
        check("sparse_rv_count", 32'(rv_cnt - rv0),    32'd1);
        check("sparse_data",     32'(rv_log[6'(rv0)]), 32'h81);
        check("sparse_vf",       32'(vf_cnt - vf0),    32'd1);
        check("sparse_no_fe",    32'(fe_cnt - fe0),    32'd0);
        check("sparse_counter",  32'(counter),         32'd1);

        // Asynchronous reset mid-byte, then a fresh frame
        apply_reset();
        send_flag(0);
        send_byte(8'h5A, 0);
        send_raw(8'h0B, 4, 0);
        #2;
        rst_i = 1'b1;
        #1;
        check("midrst_frame",   32'(frame),    32'h0);
        check("midrst_counter", 32'(counter),  32'h00);
        check("midrst_rx_data", 32'(rx_data),  32'h00);
        check("midrst_valid",   32'(rx_valid), 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        tx_ones = 0;
        @(negedge clk_i);
        #1;
        snap();
        send_byte(8'h42, 0);
        settle();
        check("midrst_no_frame_wo_flag", 32'(frame), 32'h0);
        send_flag(0);
        send_byte(8'h42, 0);
        send_flag(0);
        settle();
        check("post_rst_rv_count", 32'(rv_cnt - rv0),    32'd1);
        check("post_rst_data",     32'(rv_log[6'(rv0)]), 32'h42);
        check("post_rst_vf",       32'(vf_cnt - vf0),    32'd1);
        check("post_rst_no_pulse", 32'(ab_cnt - ab0 + fe_cnt - fe0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hdlc_rx_deframer.md
HDLC_RX_DEFRAMER -- requirements
Module: hdlc_rx_deframer

Interface
REQ-001 The block SHALL have one clock and asynchronous, active-high reset; all outputs registered on clk_i.
REQ-002 clk_i  input  1  system clock; all logic on rising edge.
REQ-003 rst_i  input  1  asynchronous active-high reset.
REQ-004 rxen  input  1  bit strobe; rx is sampled only on cycles with rxen=1.
REQ-005 rx  input  1  serial HDLC line bit, LSB-first bytes, zero-stuffed.
REQ-006 rx_data  output  8  destuffed received byte.
REQ-007 rx_valid  output  1  one-cycle pulse, rx_data valid.
REQ-008 frame  output  1  high while inside a frame (after opening flag).
REQ-009 validframe  output  1  one-cycle pulse: frame closed, byte-aligned, >=1 byte.
REQ-010 abortframe  output  1  one-cycle pulse: abort (7 consecutive ones) inside frame.
REQ-011 frameerr  output  1  one-cycle pulse: closing flag not byte-aligned.
REQ-012 counter  output  8  bytes emitted in current frame, saturates at 255.

Function
REQ-013 Raw shift register: last 8 sampled bits; flag = 0111_1110 as received, i.e. 0, six 1s, 0.
REQ-014 Ones counter: consecutive sampled 1s, saturating at 7; cleared by any sampled 0.
REQ-015 Destuffing: a 0 sampled after exactly five 1s SHALL be dropped, not assembled.
REQ-016 A sampled 1 with ones counter already >=5 SHALL not be assembled.
REQ-017 Assembly: other bits shift in LSB-first; 3-bit bit counter wraps 7->0; at wrap the byte moves to a one-byte holding register.
REQ-018 When a new byte enters the holding register and it already holds a byte, the old byte SHALL be emitted: rx_data set, rx_valid pulsed the next cycle, counter incremented.
REQ-019 States: HUNT, FRAME; reset -> HUNT.
REQ-020 HUNT: on flag detect -> FRAME, clear bit counter, holding register, counter.
REQ-021 FRAME, flag detect, bit counter==6, holding full: emit held byte, pulse validframe the same cycle as the final rx_valid; stay FRAME as opening flag of next frame (shared flag).
REQ-022 FRAME, flag detect, bit counter==6, holding empty and counter==0: back-to-back flags, no pulses, stay FRAME, re-clear.
REQ-023 FRAME, flag detect, bit counter!=6: pulse frameerr, discard holding, stay FRAME, re-clear.
REQ-024 FRAME, ones counter reaches 7: pulse abortframe, discard, -> HUNT; frame deasserts next cycle.
REQ-025 HUNT with 7+ ones (idle line): no pulses.
REQ-026 rxen=0: no state, counter or shift change; pulses SHALL be one clk_i cycle regardless of rxen.
REQ-027 Flag and abort cannot coincide; flag has priority if simultaneous detection logic overlaps.
REQ-028 frame SHALL equal (state==FRAME), registered.
REQ-029 Latency: rx_valid for byte N asserts one clk_i cycle after the rxen sample completing byte N+1 or the closing flag.

Reset
REQ-030 On rst_i: state HUNT; rx_data=0x00, rx_valid=0, frame=0, validframe=0, abortframe=0, frameerr=0, counter=0; shift register and ones counter clear; bit counter 0; holding empty.
REQ-031 Reset mid-frame SHALL discard partial data with no pulses; first post-reset frame requires a fresh opening flag.

Verification
REQ-032 Flag, bytes 0xA5 0x3C, flag, rxen every cycle -> rx_valid x2 with 0xA5, 0x3C; validframe with second; counter=2.
REQ-033 Flag, 0xFF (sent 11111 0 111), flag -> rx_data=0xFF, stuffed 0 removed, validframe.
REQ-034 Flag, 0x55, 1111111 -> abortframe pulse, no validframe, frame=0, state HUNT.
REQ-035 Flag, 0x55 plus 3 extra bits, flag -> frameerr pulse, no validframe, frame stays 1.
REQ-036 Flag, flag, flag, 0x81, flag with rxen 1-in-4 -> single rx_valid 0x81, one validframe, no frameerr.
REQ-037 rst_i asserted mid-byte of frame -> outputs reset values immediately; following frame decoded correctly.
